// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered/direct load results onto the
// single register-file write port, with write-through forwarding and pending-load flags.
module wb_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic                          alu_valid_i,
  input  logic [4:0]                    alu_rd_i,
  input  logic [31:0]                   alu_data_i,
  input  logic                          mem_valid_i,
  output logic                          mem_ready_o,
  input  logic [4:0]                    mem_rd_i,
  input  logic [31:0]                   mem_data_i,
  output logic                          write_en_o,
  output logic [4:0]                    write_addr_o,
  output logic [31:0]                   write_data_o,
  input  logic [4:0]                    read_addr1_i,
  input  logic [4:0]                    read_addr2_i,
  output logic                          fwd1_hit_o,
  output logic [31:0]                   fwd1_data_o,
  output logic                          fwd2_hit_o,
  output logic [31:0]                   fwd2_data_o,
  output logic                          pend1_o,
  output logic                          pend2_o,
  output logic [$clog2(FIFO_DEPTH):0]   pending_cnt_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t                fifo_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  ent_vld;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;

  logic    mem_fire, fifo_empty, pop, direct, push, win_vld;
  wb_ent_t win;

  always_comb begin
    mem_ready_o = reset_ni && (count < CW'(FIFO_DEPTH));
    mem_fire    = mem_valid_i && mem_ready_o;
    fifo_empty  = (count == '0);
    pop         = !alu_valid_i && !fifo_empty;
    direct      = !alu_valid_i && fifo_empty && mem_fire;
    // x0 loads are acknowledged but never occupy a slot
    push        = mem_fire && !direct && (mem_rd_i != 5'd0);
    win_vld     = 1'b0;
    win         = '0;
    if (alu_valid_i) begin
      win_vld = 1'b1;
      win     = '{rd: alu_rd_i, data: alu_data_i};
    end else if (pop) begin
      win_vld = 1'b1;
      win     = fifo_q[rd_ptr];
    end else if (direct) begin
      win_vld = 1'b1;
      win     = '{rd: mem_rd_i, data: mem_data_i};
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      write_en_o   <= 1'b0;
      write_addr_o <= '0;
      write_data_o <= '0;
      ent_vld      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      write_en_o <= win_vld && (win.rd != 5'd0);
      if (win_vld) begin
        write_addr_o <= win.rd;
        write_data_o <= win.data;
      end
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      if (push) begin
        fifo_q[wr_ptr]  <= '{rd: mem_rd_i, data: mem_data_i};
        ent_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    pend1_o = 1'b0;
    pend2_o = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_vld[i] && fifo_q[i].rd == read_addr1_i) pend1_o = 1'b1;
      if (ent_vld[i] && fifo_q[i].rd == read_addr2_i) pend2_o = 1'b1;
    end
    pend1_o = pend1_o && (read_addr1_i != 5'd0);
    pend2_o = pend2_o && (read_addr2_i != 5'd0);
  end

  assign fwd1_hit_o    = write_en_o && (write_addr_o == read_addr1_i) && (read_addr1_i != 5'd0);
  assign fwd2_hit_o    = write_en_o && (write_addr_o == read_addr2_i) && (read_addr2_i != 5'd0);
  assign fwd1_data_o   = fwd1_hit_o ? write_data_o : 32'd0;
  assign fwd2_data_o   = fwd2_hit_o ? write_data_o : 32'd0;
  assign pending_cnt_o = count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: ALU, collision, full FIFO, x0, wraparound and mid-op reset.
module tb_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic          alu_valid_i, mem_valid_i, mem_ready_o;
  logic [4:0]    alu_rd_i, mem_rd_i, read_addr1_i, read_addr2_i, write_addr_o;
  logic [31:0]   alu_data_i, mem_data_i, write_data_o, fwd1_data_o, fwd2_data_o;
  logic          write_en_o, fwd1_hit_o, fwd2_hit_o, pend1_o, pend2_o;
  logic [CW-1:0] pending_cnt_o;

  wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i),
    .write_en_o(write_en_o), .write_addr_o(write_addr_o), .write_data_o(write_data_o),
    .read_addr1_i(read_addr1_i), .read_addr2_i(read_addr2_i),
    .fwd1_hit_o(fwd1_hit_o), .fwd1_data_o(fwd1_data_o),
    .fwd2_hit_o(fwd2_hit_o), .fwd2_data_o(fwd2_data_o),
    .pend1_o(pend1_o), .pend2_o(pend2_o), .pending_cnt_o(pending_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    alu_valid_i = 1'b0;
    mem_valid_i = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 32'(write_en_o), 32'(we));
    if (we) begin
      chk({tag, "_addr"}, 32'(write_addr_o), 32'(a));
      chk({tag, "_data"}, write_data_o, d);
    end
  endtask

  initial begin
    logic [36:0]  q[$];
    logic [15:0]  pat;
    logic         exp_rdy, fire, exp_we, done;
    logic [4:0]   exp_a;
    logic [31:0]  exp_d;
    int           k;

    reset_ni = 1'b0; idle();
    alu_rd_i = '0; alu_data_i = '0; mem_rd_i = '0; mem_data_i = '0;
    read_addr1_i = '0; read_addr2_i = '0;

    // reset state
    #3;
    chk("rst_we", 32'(write_en_o), 0);
    chk("rst_addr", 32'(write_addr_o), 0);
    chk("rst_data", write_data_o, 0);
    chk("rst_cnt", 32'(pending_cnt_o), 0);
    chk("rst_ready", 32'(mem_ready_o), 0);
    chk("rst_fwd1", 32'(fwd1_hit_o), 0);
    chk("rst_pend1", 32'(pend1_o), 0);
    step(); step();
    reset_ni = 1'b1;
    #1 chk("rel_ready", 32'(mem_ready_o), 1);

    // ALU only, forwarding on both ports
    alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEADBEEF;
    read_addr1_i = 5'd5; read_addr2_i = 5'd6;
    step(); idle();
    chk_wr("alu", 1'b1, 5'd5, 32'hDEADBEEF);
    chk("alu_fwd1_hit", 32'(fwd1_hit_o), 1);
    chk("alu_fwd1_data", fwd1_data_o, 32'hDEADBEEF);
    chk("alu_fwd2_hit", 32'(fwd2_hit_o), 0);
    chk("alu_fwd2_data", fwd2_data_o, 0);
    step();
    chk("alu_idle_we", 32'(write_en_o), 0);
    chk("alu_idle_fwd1", 32'(fwd1_hit_o), 0);

    // collision: ALU wins, load buffered
    alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_data_i = 32'h11;
    mem_valid_i = 1'b1; mem_rd_i = 5'd7; mem_data_i = 32'h22;
    read_addr1_i = 5'd7; read_addr2_i = 5'd7;
    step(); idle();
    chk_wr("col1", 1'b1, 5'd3, 32'h11);
    chk("col1_cnt", 32'(pending_cnt_o), 1);
    chk("col1_pend1", 32'(pend1_o), 1);
    chk("col1_pend2", 32'(pend2_o), 1);
    step();
    chk_wr("col2", 1'b1, 5'd7, 32'h22);
    chk("col2_cnt", 32'(pending_cnt_o), 0);
    chk("col2_pend1", 32'(pend1_o), 0);

    // full FIFO under continuous ALU traffic
    alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'h100;
    mem_valid_i = 1'b1; mem_rd_i = 5'd10; mem_data_i = 32'hA0;
    step();
    chk_wr("full_a", 1'b1, 5'd1, 32'h100);
    chk("full_cnt1", 32'(pending_cnt_o), 1);
    chk("full_rdy1", 32'(mem_ready_o), 1);
    mem_rd_i = 5'd11; mem_data_i = 32'hB0;
    step();
    chk("full_cnt2", 32'(pending_cnt_o), 2);
    chk("full_rdy2", 32'(mem_ready_o), 0);
    mem_rd_i = 5'd12; mem_data_i = 32'hC0;
    step();
    chk("full_cnt_hold", 32'(pending_cnt_o), 2);
    chk("full_rdy_hold", 32'(mem_ready_o), 0);
    alu_valid_i = 1'b0;
    step();
    chk_wr("drain_a", 1'b1, 5'd10, 32'hA0);
    chk("drain_cnt1", 32'(pending_cnt_o), 1);
    chk("drain_rdy", 32'(mem_ready_o), 1);
    step(); mem_valid_i = 1'b0;
    chk_wr("drain_b", 1'b1, 5'd11, 32'hB0);
    chk("drain_cnt2", 32'(pending_cnt_o), 1);
    step();
    chk_wr("drain_c", 1'b1, 5'd12, 32'hC0);
    chk("drain_cnt3", 32'(pending_cnt_o), 0);

    // x0 handling
    mem_valid_i = 1'b1; mem_rd_i = 5'd0; mem_data_i = 32'h55;
    step(); idle();
    chk("x0_direct_we", 32'(write_en_o), 0);
    chk("x0_direct_cnt", 32'(pending_cnt_o), 0);
    alu_valid_i = 1'b1; alu_rd_i = 5'd2; alu_data_i = 32'h77;
    mem_valid_i = 1'b1; mem_rd_i = 5'd0; mem_data_i = 32'h66;
    read_addr1_i = 5'd0;
    step(); idle();
    chk_wr("x0_alu2", 1'b1, 5'd2, 32'h77);
    chk("x0_noqueue_cnt", 32'(pending_cnt_o), 0);
    chk("x0_fwd1", 32'(fwd1_hit_o), 0);
    chk("x0_pend1", 32'(pend1_o), 0);
    alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'h99;
    step(); idle();
    chk("x0_alu_we", 32'(write_en_o), 0);

    // wraparound: 10 loads interleaved with ALU bursts
    pat = 16'hB6D3; k = 0; done = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      alu_valid_i = pat[c % 16]; alu_rd_i = 5'd1; alu_data_i = 32'h1000 + 32'(c);
      mem_valid_i = (k < 10); mem_rd_i = 5'(16 + k); mem_data_i = 32'hC0DE_0000 + 32'(k);
      exp_rdy = (q.size() < DEPTH);
      #1 chk("wrap_ready", 32'(mem_ready_o), 32'(exp_rdy));
      fire = mem_valid_i && exp_rdy;
      exp_we = 1'b1; exp_a = '0; exp_d = '0;
      if (alu_valid_i) begin
        exp_a = alu_rd_i; exp_d = alu_data_i;
        if (fire) q.push_back({mem_rd_i, mem_data_i});
      end else if (q.size() > 0) begin
        {exp_a, exp_d} = q.pop_front();
        if (fire) q.push_back({mem_rd_i, mem_data_i});
      end else if (fire) begin
        exp_a = mem_rd_i; exp_d = mem_data_i;
      end else begin
        exp_we = 1'b0;
      end
      if (fire) k++;
      step();
      chk_wr("wrap", exp_we, exp_a, exp_d);
      chk("wrap_cnt", 32'(pending_cnt_o), 32'(q.size()));
      if (k == 10 && q.size() == 0) done = 1'b1;
    end
    idle();
    chk("wrap_done", 32'(done), 1);

    // reset mid-operation with two buffered loads
    alu_valid_i = 1'b1; alu_rd_i = 5'd4; alu_data_i = 32'h44;
    mem_valid_i = 1'b1; mem_rd_i = 5'd8; mem_data_i = 32'h88;
    step();
    mem_rd_i = 5'd9; mem_data_i = 32'h99;
    step(); idle();
    read_addr1_i = 5'd8; read_addr2_i = 5'd4;
    #1;
    chk("mid_cnt", 32'(pending_cnt_o), 2);
    chk("mid_pend1", 32'(pend1_o), 1);
    chk("mid_fwd2", 32'(fwd2_hit_o), 1);
    reset_ni = 1'b0;
    #1;
    chk("mrst_we", 32'(write_en_o), 0);
    chk("mrst_addr", 32'(write_addr_o), 0);
    chk("mrst_data", write_data_o, 0);
    chk("mrst_cnt", 32'(pending_cnt_o), 0);
    chk("mrst_ready", 32'(mem_ready_o), 0);
    chk("mrst_pend1", 32'(pend1_o), 0);
    chk("mrst_fwd2", 32'(fwd2_hit_o), 0);
    step(); step();
    reset_ni = 1'b1;
    #1 chk("mrel_ready", 32'(mem_ready_o), 1);
    step();
    chk("mrel_we1", 32'(write_en_o), 0);
    chk("mrel_cnt", 32'(pending_cnt_o), 0);
    step();
    chk("mrel_we2", 32'(write_en_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
